// File: rtl/camera_capture_ctrl_mc.sv
// rtl/camera_capture_ctrl_mc.sv - multi-frame camera capture gate with frame tagging and test generator
//
// Ports:
//   sys_clk, sys_rst         clock, asynchronous active-high reset
//   cl_pixel/cl_pixel_vld    PHY pixel beat and its valid
//   cl_new_frame             PHY start-of-frame pulse
//   cl_frame_valid           PHY frame-valid level
//   image_width/height       frame geometry (pixels per line, lines per frame)
//   num_frames               frames per capture (0 behaves as 1)
//   capture/abort            start and abort pulses
//   test_mode/test_pattern   select internal generator and its pattern
//   pixel/data_vld           registered output beat
//   sof/eol/eof              frame/line markers aligned with the output beat
//   new_frame                registered start-of-frame pulse from the active source
//   capture_busy             capture in progress
//   capture_end              sticky completion flag
//   frames_done              frames completed in the current capture
//   size_err                 sticky geometry / framing error flag
module camera_capture_ctrl_mc #(
  parameter int PIX_PER_CLK = 4,
  parameter int PIX_W       = 12,
  parameter int DIM_W       = 16,
  parameter int FRM_CNT_W   = 8,
  parameter int LINE_GAP    = 256
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic [PIX_PER_CLK*PIX_W-1:0] cl_pixel,
  input  logic                         cl_pixel_vld,
  input  logic                         cl_new_frame,
  input  logic                         cl_frame_valid,
  input  logic [DIM_W-1:0]             image_width,
  input  logic [DIM_W-1:0]             image_height,
  input  logic [FRM_CNT_W-1:0]         num_frames,
  input  logic                         capture,
  input  logic                         abort,
  input  logic                         test_mode,
  input  logic [1:0]                   test_pattern,
  output logic [PIX_PER_CLK*PIX_W-1:0] pixel,
  output logic                         data_vld,
  output logic                         sof,
  output logic                         eol,
  output logic                         eof,
  output logic                         new_frame,
  output logic                         capture_busy,
  output logic                         capture_end,
  output logic [FRM_CNT_W-1:0]         frames_done,
  output logic                         size_err
);

  localparam int BW    = PIX_PER_CLK * PIX_W;
  localparam int GAP_W = $clog2(LINE_GAP + 1);
  localparam logic [DIM_W-1:0] PPC      = DIM_W'(PIX_PER_CLK);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(LINE_GAP - 1);

  // 0xA5A5... pattern taken MSB-first and cut to PIX_W bits
  function automatic logic [PIX_W-1:0] a5_const();
    logic [7:0]       pat;
    logic [PIX_W-1:0] v;
    pat = 8'hA5;
    v   = '0;
    for (int b = 0; b < PIX_W; b++) v[PIX_W-1-b] = pat[7-(b%8)];
    return v;
  endfunction
  localparam logic [PIX_W-1:0] A5 = a5_const();

  typedef enum logic [2:0] {IDLE, SKIP, ARMED, CAPT, DONE} state_t;
  typedef enum logic [1:0] {G_OFF, G_NF, G_LINE, G_GAP} gen_t;

  state_t               state;
  gen_t                 gen_phase;
  logic [DIM_W-1:0]     w_r, h_r, col, line;
  logic [FRM_CNT_W-1:0] nf_r;
  logic                 tm_r;
  logic [1:0]           tp_r;
  logic [DIM_W-1:0]     gen_col, gen_line;
  logic [GAP_W-1:0]     gen_gap;

  logic [BW-1:0]        gen_pix;
  logic [DIM_W-1:0]     gc, gs;

  // Generator pixels for the current generator beat position
  always_comb begin
    gen_pix = '0;
    gc      = '0;
    gs      = '0;
    for (int i = 0; i < PIX_PER_CLK; i++) begin
      gc = gen_col + DIM_W'(i);
      gs = gen_line + gc;
      case (tp_r)
        2'd0:    gen_pix[i*PIX_W +: PIX_W] = PIX_W'(gs);
        2'd1:    gen_pix[i*PIX_W +: PIX_W] = PIX_W'(gc);
        2'd2:    gen_pix[i*PIX_W +: PIX_W] = (gen_line[3] ^ gc[3]) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
        default: gen_pix[i*PIX_W +: PIX_W] = A5;
      endcase
    end
  end

  // Source mux: the generator owns the input side for the whole test-mode capture
  logic          sel_gen, src_vld, src_nf, src_fv;
  logic [BW-1:0] src_pix;
  assign sel_gen = tm_r && (state != IDLE);
  assign src_vld = sel_gen ? (gen_phase == G_LINE) : cl_pixel_vld;
  assign src_nf  = sel_gen ? (gen_phase == G_NF)   : cl_new_frame;
  assign src_fv  = sel_gen ? (gen_phase == G_LINE || gen_phase == G_GAP) : cl_frame_valid;
  assign src_pix = sel_gen ? gen_pix : cl_pixel;

  // A beat arriving with new_frame is position (0,0) of the new frame
  logic [DIM_W-1:0]     bc, bl;
  logic                 last_col, last_line, take, size_bad;
  logic [FRM_CNT_W-1:0] fd_next, nf_eff;
  assign bc        = src_nf ? '0 : col;
  assign bl        = src_nf ? '0 : line;
  assign last_col  = (bc == w_r - PPC);
  assign last_line = (bl == h_r - DIM_W'(1));
  assign fd_next   = frames_done + FRM_CNT_W'(1);
  assign take      = !abort && src_vld &&
                     ((state == ARMED && src_nf) || (state == CAPT && src_fv));
  assign size_bad  = (image_width == '0) || (image_height == '0) ||
                     ((image_width % PPC) != '0);
  assign nf_eff    = (num_frames == '0) ? FRM_CNT_W'(1) : num_frames;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state        <= IDLE;
      w_r          <= '0;
      h_r          <= '0;
      nf_r         <= '0;
      tm_r         <= 1'b0;
      tp_r         <= '0;
      col          <= '0;
      line         <= '0;
      pixel        <= '0;
      data_vld     <= 1'b0;
      sof          <= 1'b0;
      eol          <= 1'b0;
      eof          <= 1'b0;
      new_frame    <= 1'b0;
      capture_busy <= 1'b0;
      capture_end  <= 1'b0;
      frames_done  <= '0;
      size_err     <= 1'b0;
    end else begin
      data_vld  <= 1'b0;
      sof       <= 1'b0;
      eol       <= 1'b0;
      eof       <= 1'b0;
      new_frame <= src_nf;
      if (abort && state != IDLE) begin
        state        <= IDLE;
        capture_busy <= 1'b0;
        capture_end  <= 1'b1;
      end else begin
        case (state)
          IDLE: if (capture) begin
            if (size_bad) begin
              size_err    <= 1'b1;
              capture_end <= 1'b1;
            end else begin
              w_r          <= image_width;
              h_r          <= image_height;
              nf_r         <= nf_eff;
              tm_r         <= test_mode;
              tp_r         <= test_pattern;
              col          <= '0;
              line         <= '0;
              capture_end  <= 1'b0;
              size_err     <= 1'b0;
              frames_done  <= '0;
              capture_busy <= 1'b1;
              state        <= (!test_mode && cl_frame_valid) ? SKIP : ARMED;
            end
          end
          SKIP: if (!src_fv) state <= ARMED;
          ARMED: if (src_nf) begin
            state <= CAPT;
            col   <= '0;
            line  <= '0;
          end
          CAPT: begin
            if (!src_fv) begin
              size_err <= 1'b1;
              state    <= ARMED;
            end else if (src_nf) begin
              size_err <= 1'b1;
              col      <= '0;
              line     <= '0;
            end
          end
          DONE: begin
            capture_end  <= 1'b1;
            capture_busy <= 1'b0;
            state        <= IDLE;
          end
          default: state <= IDLE;
        endcase
        // Beat handling last so frame completion overrides the state set above
        if (take) begin
          data_vld <= 1'b1;
          pixel    <= src_pix;
          sof      <= (bc == '0) && (bl == '0);
          eol      <= last_col;
          eof      <= last_col && last_line;
          if (last_col) begin
            col <= '0;
            if (last_line) begin
              line        <= '0;
              frames_done <= fd_next;
              state       <= (fd_next == nf_r) ? DONE : ARMED;
            end else begin
              line <= bl + DIM_W'(1);
            end
          end else begin
            col <= bc + PPC;
          end
        end
      end
    end
  end

  // Generator: new_frame pulse one cycle after ARMED, then lines separated by LINE_GAP idles
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      gen_phase <= G_OFF;
      gen_col   <= '0;
      gen_line  <= '0;
      gen_gap   <= '0;
    end else if (abort || !tm_r || state == IDLE || state == DONE) begin
      gen_phase <= G_OFF;
      gen_col   <= '0;
      gen_line  <= '0;
      gen_gap   <= '0;
    end else begin
      case (gen_phase)
        G_OFF: begin
          gen_col  <= '0;
          gen_line <= '0;
          if (state == ARMED) gen_phase <= G_NF;
        end
        G_NF: gen_phase <= G_LINE;
        G_LINE: begin
          if (gen_col == w_r - PPC) begin
            gen_col <= '0;
            if (gen_line == h_r - DIM_W'(1)) begin
              gen_line  <= '0;
              gen_phase <= G_OFF;
            end else begin
              gen_line  <= gen_line + DIM_W'(1);
              gen_gap   <= GAP_LAST;
              gen_phase <= G_GAP;
            end
          end else begin
            gen_col <= gen_col + PPC;
          end
        end
        default: begin
          if (gen_gap == '0) gen_phase <= G_LINE;
          else gen_gap <= gen_gap - GAP_W'(1);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_camera_capture_ctrl_mc.sv
// tb/tb_camera_capture_ctrl_mc.sv - directed self-checking bench for camera_capture_ctrl_mc
module tb_camera_capture_ctrl_mc;
  localparam int PPC = 4;
  localparam int PW  = 12;
  localparam int DW  = 16;
  localparam int FW  = 8;
  localparam int GAP = 256;
  localparam int BW  = PPC * PW;

  logic          sys_clk, sys_rst;
  logic [BW-1:0] cl_pixel;
  logic          cl_pixel_vld, cl_new_frame, cl_frame_valid;
  logic [DW-1:0] image_width, image_height;
  logic [FW-1:0] num_frames;
  logic          capture, abort, test_mode;
  logic [1:0]    test_pattern;
  logic [BW-1:0] pixel;
  logic          data_vld, sof, eol, eof, new_frame, capture_busy, capture_end, size_err;
  logic [FW-1:0] frames_done;

  camera_capture_ctrl_mc #(
    .PIX_PER_CLK(PPC), .PIX_W(PW), .DIM_W(DW), .FRM_CNT_W(FW), .LINE_GAP(GAP)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cl_pixel(cl_pixel), .cl_pixel_vld(cl_pixel_vld), .cl_new_frame(cl_new_frame),
    .cl_frame_valid(cl_frame_valid), .image_width(image_width), .image_height(image_height),
    .num_frames(num_frames), .capture(capture), .abort(abort), .test_mode(test_mode),
    .test_pattern(test_pattern), .pixel(pixel), .data_vld(data_vld), .sof(sof), .eol(eol),
    .eof(eof), .new_frame(new_frame), .capture_busy(capture_busy), .capture_end(capture_end),
    .frames_done(frames_done), .size_err(size_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct {
    logic [BW-1:0] pix;
    logic          sof, eol, eof;
    int            cyc;
  } beat_t;

  beat_t mon_q[$];
  int    nf_cnt = 0;

  always @(negedge sys_clk) begin
    beat_t b;
    if (data_vld === 1'b1) begin
      b.pix = pixel; b.sof = sof; b.eol = eol; b.eof = eof; b.cyc = cyc;
      mon_q.push_back(b);
    end
    if (new_frame === 1'b1) nf_cnt++;
  end

  int checks = 0;
  int errors = 0;

  task automatic step;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic idle_inputs;
    cl_pixel = '0; cl_pixel_vld = 0; cl_new_frame = 0; cl_frame_valid = 0;
    capture = 0; abort = 0;
  endtask

  task automatic do_capture(input int w, input int h, input int nf, input bit tm, input int tp);
    image_width = DW'(w); image_height = DW'(h); num_frames = FW'(nf);
    test_mode = tm; test_pattern = 2'(tp);
    capture = 1; step; capture = 0;
  endtask

  task automatic phy_frame(input int nbeats, input int base, input bit end_fv);
    for (int k = 0; k < nbeats; k++) begin
      cl_frame_valid = 1; cl_pixel_vld = 1; cl_new_frame = (k == 0);
      cl_pixel = BW'(base + k);
      step;
    end
    cl_new_frame = 0; cl_pixel_vld = 0;
    if (end_fv) begin
      cl_frame_valid = 0;
      repeat (3) step;
    end
  endtask

  task automatic test_reset;
    logic [BW+FW+7:0] all_out;
    sys_rst = 1; idle_inputs();
    image_width = 0; image_height = 0; num_frames = 0; test_mode = 0; test_pattern = 0;
    repeat (3) step;
    all_out = {data_vld, sof, eol, eof, new_frame, capture_busy, capture_end, size_err, frames_done, pixel};
    checks++; if (all_out !== '0) begin errors++; $display("FAIL reset_outputs got %0h exp 0", all_out); end
    sys_rst = 0;
    step;
  endtask

  task automatic test_basic;
    logic [2:0] exp_f;
    mon_q.delete(); nf_cnt = 0;
    do_capture(16, 3, 1, 0, 0);
    checks++; if (capture_busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", capture_busy); end
    checks++; if (capture_end !== 1'b0) begin errors++; $display("FAIL basic_end_clr got %b exp 0", capture_end); end
    phy_frame(12, 'h100, 1);
    checks++; if (mon_q.size() != 12) begin errors++; $display("FAIL basic_beats got %0d exp 12", mon_q.size()); end
    for (int j = 0; j < mon_q.size() && j < 12; j++) begin
      exp_f = {j == 0, (j % 4) == 3, j == 11};
      checks++; if ({mon_q[j].sof, mon_q[j].eol, mon_q[j].eof} !== exp_f) begin
        errors++; $display("FAIL basic_flags beat %0d got %b exp %b", j, {mon_q[j].sof, mon_q[j].eol, mon_q[j].eof}, exp_f); end
      checks++; if (mon_q[j].pix !== BW'('h100 + j)) begin
        errors++; $display("FAIL basic_pix beat %0d got %0h exp %0h", j, mon_q[j].pix, 'h100 + j); end
    end
    checks++; if (frames_done !== 8'd1) begin errors++; $display("FAIL basic_frames got %0d exp 1", frames_done); end
    checks++; if (capture_end !== 1'b1) begin errors++; $display("FAIL basic_end got %b exp 1", capture_end); end
    checks++; if (size_err !== 1'b0) begin errors++; $display("FAIL basic_size_err got %b exp 0", size_err); end
    checks++; if (capture_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done got %b exp 0", capture_busy); end
    checks++; if (nf_cnt != 1) begin errors++; $display("FAIL basic_new_frame got %0d exp 1", nf_cnt); end
  endtask

  task automatic test_illegal_size;
    mon_q.delete();
    do_capture(10, 3, 1, 0, 0);
    checks++; if (size_err !== 1'b1) begin errors++; $display("FAIL illegal_size_err got %b exp 1", size_err); end
    checks++; if (capture_end !== 1'b1) begin errors++; $display("FAIL illegal_end got %b exp 1", capture_end); end
    checks++; if (capture_busy !== 1'b0) begin errors++; $display("FAIL illegal_busy got %b exp 0", capture_busy); end
    phy_frame(12, 'h300, 1);
    checks++; if (mon_q.size() != 0) begin errors++; $display("FAIL illegal_no_data got %0d exp 0", mon_q.size()); end
  endtask

  task automatic test_skip;
    int nf_drive;
    mon_q.delete();
    image_width = 16; image_height = 3; num_frames = 1; test_mode = 0; test_pattern = 0;
    cl_frame_valid = 1; cl_pixel_vld = 1;
    for (int k = 0; k < 3; k++) begin cl_pixel = BW'('h500 + k); step; end
    capture = 1; cl_pixel = BW'('h503); step; capture = 0;
    checks++; if (capture_busy !== 1'b1) begin errors++; $display("FAIL skip_busy got %b exp 1", capture_busy); end
    checks++; if (size_err !== 1'b0) begin errors++; $display("FAIL skip_err_clr got %b exp 0", size_err); end
    for (int k = 4; k < 7; k++) begin cl_pixel = BW'('h500 + k); step; end
    cl_frame_valid = 0; cl_pixel_vld = 0;
    repeat (2) step;
    nf_drive = cyc;
    phy_frame(12, 'h600, 1);
    checks++; if (mon_q.size() != 12) begin errors++; $display("FAIL skip_beats got %0d exp 12", mon_q.size()); end
    if (mon_q.size() > 0) begin
      checks++; if (mon_q[0].cyc != nf_drive + 1) begin errors++; $display("FAIL skip_latency got %0d exp %0d", mon_q[0].cyc, nf_drive + 1); end
      checks++; if (mon_q[0].pix !== BW'('h600)) begin errors++; $display("FAIL skip_first_pix got %0h exp 600", mon_q[0].pix); end
    end
    checks++; if (frames_done !== 8'd1) begin errors++; $display("FAIL skip_frames got %0d exp 1", frames_done); end
    checks++; if (capture_end !== 1'b1) begin errors++; $display("FAIL skip_end got %b exp 1", capture_end); end
  endtask

  task automatic test_short_frame;
    mon_q.delete();
    do_capture(16, 3, 1, 0, 0);
    phy_frame(5, 'h700, 0);
    phy_frame(12, 'h800, 1);
    checks++; if (size_err !== 1'b1) begin errors++; $display("FAIL short_size_err got %b exp 1", size_err); end
    checks++; if (frames_done !== 8'd1) begin errors++; $display("FAIL short_frames got %0d exp 1", frames_done); end
    checks++; if (mon_q.size() != 17) begin errors++; $display("FAIL short_beats got %0d exp 17", mon_q.size()); end
    if (mon_q.size() == 17) begin
      checks++; if ({mon_q[5].sof, mon_q[5].pix} !== {1'b1, BW'('h800)}) begin
        errors++; $display("FAIL short_restart got sof=%b pix=%0h exp sof=1 pix=800", mon_q[5].sof, mon_q[5].pix); end
      checks++; if ({mon_q[4].eof, mon_q[16].eof} !== 2'b01) begin
        errors++; $display("FAIL short_eof got %b exp 01", {mon_q[4].eof, mon_q[16].eof}); end
    end
    checks++; if (capture_end !== 1'b1) begin errors++; $display("FAIL short_end got %b exp 1", capture_end); end
  endtask

  task automatic test_testmode;
    logic [BW-1:0] exp_pix;
    logic [2:0]    exp_f;
    int            n, b, l, c0;
    mon_q.delete(); nf_cnt = 0;
    do_capture(8, 2, 3, 1, 0);
    n = 0;
    while (capture_end !== 1'b1 && n < 3000) begin step; n++; end
    checks++; if (capture_end !== 1'b1) begin errors++; $display("FAIL tm_timeout got capture_end=%b exp 1", capture_end); end
    checks++; if (mon_q.size() != 12) begin errors++; $display("FAIL tm_beats got %0d exp 12", mon_q.size()); end
    for (int j = 0; j < mon_q.size() && j < 12; j++) begin
      b = j % 4; l = b / 2; c0 = (b % 2) * 4;
      for (int i = 0; i < PPC; i++) exp_pix[i*PW +: PW] = PW'(l + c0 + i);
      exp_f = {b == 0, (b % 2) == 1, b == 3};
      checks++; if (mon_q[j].pix !== exp_pix) begin errors++; $display("FAIL tm_pix beat %0d got %0h exp %0h", j, mon_q[j].pix, exp_pix); end
      checks++; if ({mon_q[j].sof, mon_q[j].eol, mon_q[j].eof} !== exp_f) begin
        errors++; $display("FAIL tm_flags beat %0d got %b exp %b", j, {mon_q[j].sof, mon_q[j].eol, mon_q[j].eof}, exp_f); end
    end
    if (mon_q.size() > 2) begin
      checks++; if (mon_q[2].pix[PW-1:0] !== 12'd1) begin errors++; $display("FAIL tm_beat2_pix0 got %0d exp 1", mon_q[2].pix[PW-1:0]); end
      checks++; if (mon_q[2].cyc - mon_q[1].cyc != GAP + 1) begin
        errors++; $display("FAIL tm_line_gap got %0d exp %0d", mon_q[2].cyc - mon_q[1].cyc, GAP + 1); end
    end
    checks++; if (frames_done !== 8'd3) begin errors++; $display("FAIL tm_frames got %0d exp 3", frames_done); end
    checks++; if (nf_cnt != 3) begin errors++; $display("FAIL tm_new_frame got %0d exp 3", nf_cnt); end
  endtask

  task automatic test_patterns;
    logic [BW-1:0] exp_pix;
    int            n, c;
    for (int p = 1; p < 4; p++) begin
      mon_q.delete();
      do_capture(16, 1, 0, 1, p);
      n = 0;
      while (capture_end !== 1'b1 && n < 100) begin step; n++; end
      checks++; if (capture_end !== 1'b1) begin errors++; $display("FAIL pat%0d_timeout got capture_end=%b exp 1", p, capture_end); end
      checks++; if (mon_q.size() != 4) begin errors++; $display("FAIL pat%0d_beats got %0d exp 4", p, mon_q.size()); end
      for (int j = 0; j < mon_q.size() && j < 4; j++) begin
        for (int i = 0; i < PPC; i++) begin
          c = j * 4 + i;
          case (p)
            1: exp_pix[i*PW +: PW] = PW'(c);
            2: exp_pix[i*PW +: PW] = ((c >> 3) & 1) ? 12'hFFF : 12'h000;
            default: exp_pix[i*PW +: PW] = 12'hA5A;
          endcase
        end
        checks++; if (mon_q[j].pix !== exp_pix) begin errors++; $display("FAIL pat%0d_pix beat %0d got %0h exp %0h", p, j, mon_q[j].pix, exp_pix); end
      end
      checks++; if (frames_done !== 8'd1) begin errors++; $display("FAIL pat%0d_frames got %0d exp 1", p, frames_done); end
    end
  endtask

  task automatic test_abort;
    int eofs;
    mon_q.delete();
    do_capture(16, 3, 1, 0, 0);
    phy_frame(5, 'h900, 0);
    abort = 1; cl_pixel_vld = 1; cl_pixel = BW'('h905);
    step;
    abort = 0;
    checks++; if (capture_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", capture_busy); end
    checks++; if (data_vld !== 1'b0) begin errors++; $display("FAIL abort_vld got %b exp 0", data_vld); end
    checks++; if (capture_end !== 1'b1) begin errors++; $display("FAIL abort_end got %b exp 1", capture_end); end
    for (int k = 6; k < 12; k++) begin cl_pixel = BW'('h900 + k); step; end
    cl_pixel_vld = 0; cl_frame_valid = 0;
    repeat (3) step;
    eofs = 0;
    foreach (mon_q[j]) if (mon_q[j].eof === 1'b1) eofs++;
    checks++; if (mon_q.size() != 5) begin errors++; $display("FAIL abort_beats got %0d exp 5", mon_q.size()); end
    checks++; if (eofs != 0) begin errors++; $display("FAIL abort_eof got %0d exp 0", eofs); end
    checks++; if (frames_done !== 8'd0) begin errors++; $display("FAIL abort_frames got %0d exp 0", frames_done); end
  endtask

  task automatic test_reset_mid_capt;
    logic [BW+FW+7:0] all_out;
    mon_q.delete();
    do_capture(16, 3, 1, 0, 0);
    phy_frame(4, 'hA00, 0);
    checks++; if (data_vld !== 1'b1) begin errors++; $display("FAIL rstmid_pre_vld got %b exp 1", data_vld); end
    #2 sys_rst = 1;
    #1;
    all_out = {data_vld, sof, eol, eof, new_frame, capture_busy, capture_end, size_err, frames_done, pixel};
    checks++; if (all_out !== '0) begin errors++; $display("FAIL rstmid_outputs got %0h exp 0", all_out); end
    idle_inputs();
    repeat (2) step;
    sys_rst = 0;
    step;
    test_basic();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_illegal_size();
    test_skip();
    test_short_frame();
    test_testmode();
    test_patterns();
    test_abort();
    test_reset_mid_capt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
